// File: rtl/lopd_normalizer.sv
// Two-stage valid/ready normalizer: left-shifts a mantissa so its leading one reaches the MSB and adjusts the exponent.
// Optional macro NORM_CHECK_EN adds an independent leading-one checker that drives o_err.
module lopd_normalizer #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_EXP  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [SIZE_LOPD-1:0] i_one_position,
  input  logic                 i_zero_flag,
  input  logic [SIZE_EXP-1:0]  i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic [SIZE_LOPD-1:0] o_shift,
  output logic                 o_zero,
  output logic                 o_underflow,
  output logic                 o_err
);

  // Common width for comparing and subtracting exponent against shift amount.
  localparam int CW = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD;
  localparam logic [SIZE_LOPD-1:0] MSB_POS = SIZE_LOPD'(SIZE_DATA - 1);

  logic                 s1_valid;
  logic [SIZE_DATA-1:0] s1_data;
  logic [SIZE_EXP-1:0]  s1_exp;
  logic                 s1_zero;
  logic [SIZE_LOPD-1:0] s1_shift;

  logic                 s2_adv;
  logic                 bad_pos;
  logic [SIZE_LOPD-1:0] req_shift;

  logic [SIZE_DATA-1:0] nxt_data;
  logic [SIZE_EXP-1:0]  nxt_exp;
  logic [SIZE_LOPD-1:0] nxt_shift;
  logic                 nxt_zero;
  logic                 nxt_underflow;
  logic [CW-1:0]        exp_w;
  logic [CW-1:0]        shift_w;

  assign s2_adv    = !o_valid || i_ready;
  assign o_ready   = !s1_valid || s2_adv;
  assign bad_pos   = i_one_position > MSB_POS;
  assign req_shift = bad_pos ? '0 : (MSB_POS - i_one_position);

`ifdef NORM_CHECK_EN
  logic                 s1_err;
  logic                 in_err;
  logic                 det_found;
  logic [SIZE_LOPD-1:0] det_pos;

  // Independent priority scan; the highest set bit wins because later iterations overwrite.
  always_comb begin
    det_found = 1'b0;
    det_pos   = '0;
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (i_data[i]) begin
        det_found = 1'b1;
        det_pos   = SIZE_LOPD'(i);
      end
    end
    in_err = bad_pos || (det_found == i_zero_flag) ||
             (det_found && (det_pos != i_one_position));
  end
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
      s1_zero  <= 1'b0;
      s1_shift <= '0;
`ifdef NORM_CHECK_EN
      s1_err   <= 1'b0;
`endif
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_data  <= i_data;
        s1_exp   <= i_exp;
        s1_zero  <= i_zero_flag;
        s1_shift <= req_shift;
`ifdef NORM_CHECK_EN
        s1_err   <= in_err;
`endif
      end
    end
  end

  // Shift is limited by the exponent so the result never goes below exponent 0.
  always_comb begin
    exp_w         = CW'(s1_exp);
    shift_w       = CW'(s1_shift);
    nxt_data      = '0;
    nxt_exp       = '0;
    nxt_shift     = '0;
    nxt_zero      = 1'b0;
    nxt_underflow = 1'b0;
    if (s1_zero) begin
      nxt_zero = 1'b1;
    end else if (exp_w > shift_w) begin
      nxt_data  = s1_data << s1_shift;
      nxt_exp   = SIZE_EXP'(exp_w - shift_w);
      nxt_shift = s1_shift;
    end else begin
      nxt_data      = s1_data << s1_exp;
      nxt_shift     = SIZE_LOPD'(exp_w);
      nxt_underflow = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_exp       <= '0;
      o_shift     <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
`ifdef NORM_CHECK_EN
      o_err       <= 1'b0;
`endif
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data      <= nxt_data;
        o_exp       <= nxt_exp;
        o_shift     <= nxt_shift;
        o_zero      <= nxt_zero;
        o_underflow <= nxt_underflow;
`ifdef NORM_CHECK_EN
        o_err       <= s1_err;
`endif
      end
    end
  end

endmodule

// File: doc/lopd_normalizer.md
Name: lopd_normalizer

Overview:
- Consumer and inverse of the leading-one position detector: takes a mantissa plus its leading-one position and zero flag, and left-shifts the mantissa so the leading one lands in the MSB.
- Adjusts the exponent by the shift amount and handles the zero and underflow (denormal) cases.
- Sits after the LOPD in the FP add/sub normalization path.
- 2-stage valid/ready pipeline, throughput 1 item/cycle.

Parameters:
SIZE_DATA, 24, mantissa width
SIZE_LOPD, 5, width of position/shift fields; must satisfy 2**SIZE_LOPD >= SIZE_DATA
SIZE_EXP, 8, exponent width (unsigned, biased)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  upstream item valid
o_ready  output  1  block can accept an item this cycle
i_data  input  SIZE_DATA  unnormalized mantissa
i_one_position  input  SIZE_LOPD  leading-one index from the LOPD (0 = LSB)
i_zero_flag  input  1  from the LOPD; 1 = i_data is all zero
i_exp  input  SIZE_EXP  exponent before normalization
o_valid  output  1  result valid
i_ready  input  1  downstream accepts the result
o_data  output  SIZE_DATA  normalized mantissa
o_exp  output  SIZE_EXP  adjusted exponent
o_shift  output  SIZE_LOPD  left-shift amount actually applied
o_zero  output  1  result is zero
o_underflow  output  1  exponent clamped to 0; result is denormal
o_err  output  1  position inconsistent with data (see Optional Feature)

Behaviour:
- Reset (i_rst_n=0 at a rising edge): s1_valid=0, o_valid=0; o_data, o_exp, o_shift, o_zero, o_underflow, o_err all 0.
- Reset mid-operation discards in-flight items. o_ready=1 in the first cycle after reset.
- Handshake rules:
  - s2_adv = !o_valid || i_ready.
  - o_ready = !s1_valid || s2_adv (combinational; no combinational path from i_valid).
  - Accept on i_valid && o_ready. Deliver on o_valid && i_ready.
- Stage 1 (capture register):
  - On accept, store data, exp and zero flag.
  - Store req_shift = SIZE_DATA-1-i_one_position.
  - If i_one_position >= SIZE_DATA, force req_shift = 0 and mark the item as bad position.
- Stage 2 (output register), loaded when s2_adv, valid = s1_valid:
  - zero item: o_data=0, o_exp=0, o_shift=0, o_zero=1, o_underflow=0.
  - i_exp > req_shift: o_data = data << req_shift, o_exp = i_exp - req_shift, o_shift = req_shift.
  - i_exp <= req_shift: shift by i_exp only; o_data = data << i_exp, o_exp = 0, o_shift = i_exp (truncated to SIZE_LOPD), o_underflow = 1.
- Latency: exactly 2 cycles from accept to o_valid when i_ready=1. Back-to-back accepts sustain 1 item/cycle.
- Backpressure:
  - While o_valid && !i_ready, all o_* outputs are held stable.
  - Stage 1 holds its item; o_ready drops once stage 1 is occupied.
  - No items are lost or duplicated; order is preserved.
- Simultaneous deliver and accept in the same cycle: both stages advance. Full throughput, no bubble.
- i_valid with o_ready=0: ignored; upstream must hold its inputs.

Optional Feature:
- Macro NORM_CHECK_EN.
- Defined: stage 1 computes an independent leading-one index of i_data and compares it with i_one_position and i_zero_flag.
  - o_err=1 (registered alongside the result) on mismatch or bad position.
  - Data path result is unchanged.
- Undefined: checker logic is absent and o_err is tied to 0.

Test Plan:
- i_data=24'h000001, pos=0, exp=100 -> 2 cycles later o_data=24'h800000, o_shift=23, o_exp=77, o_zero=0, o_underflow=0.
- i_data=24'h800000, pos=23, exp=5 -> o_data=24'h800000, o_shift=0, o_exp=5.
- i_data=0, zero_flag=1, exp=50 -> o_data=0, o_exp=0, o_shift=0, o_zero=1.
- i_data=24'h000010, pos=4, exp=3 -> o_data=24'h000080, o_exp=0, o_shift=3, o_underflow=1.
- i_ready=0 for 6 cycles, 3 items offered back-to-back -> 2 accepted, then o_ready=0 and o_* stable; on i_ready=1 all 3 items delivered in order, 1 per cycle.
- NORM_CHECK_EN defined: i_data=24'h000300 with pos=5 -> o_err=1. Same item with pos=9 -> o_err=0.
- i_rst_n=0 with both stages full -> next cycle o_valid=0, outputs 0, o_ready=1.
